// File: rtl/stage_if_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// One request outstanding: imem_addr is held stable from req until the cycle that carries ack.
interface stage_if_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: owns the PC, fetches over a req/ack bus and fills the IF/ID register.
// A one-entry buffer catches a response that lands while ID is stalled.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_addr,
    stage_if_if.master  imem,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        DROP  = 2'b01,
        FULL  = 2'b10
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] pc_next(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        buf_valid_r, buf_valid_s;
    logic [31:0] buf_pc_r, buf_pc_s;
    logic [31:0] buf_inst_r, buf_inst_s;
    logic        req_r, req_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] id_pc_r, id_pc_s;
    logic [31:0] id_inst_r, id_inst_s;
    logic        id_valid_r, id_valid_s;
    logic        ack_s;
    logic        redirect_s;

    // An ack only counts against a request we actually issued; this also drops late acks after reset.
    assign ack_s      = imem.imem_ack & req_r;
    assign redirect_s = br & ~stall;

    // Next-state, PC, fetch buffer and IF/ID contents.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        buf_valid_s = buf_valid_r;
        buf_pc_s    = buf_pc_r;
        buf_inst_s  = buf_inst_r;
        id_pc_s     = id_pc_r;
        id_inst_s   = id_inst_r;
        id_valid_s  = id_valid_r;
        case (state_r)
            FETCH: begin
                if (redirect_s) begin
                    pc_s        = word_align(br_addr);
                    id_inst_s   = NOP_INST;
                    id_valid_s  = 1'b0;
                    buf_valid_s = 1'b0;
                    if (ack_s) begin
                        state_s = FETCH;
                    end else begin
                        state_s = DROP;
                    end
                end else if (ack_s) begin
                    pc_s = pc_next(pc_r);
                    if (stall) begin
                        buf_pc_s    = pc_r;
                        buf_inst_s  = imem.imem_rdata;
                        buf_valid_s = 1'b1;
                        state_s     = FULL;
                    end else begin
                        id_pc_s    = pc_r;
                        id_inst_s  = imem.imem_rdata;
                        id_valid_s = 1'b1;
                        state_s    = FETCH;
                    end
                end else if (!stall) begin
                    id_inst_s  = NOP_INST;
                    id_valid_s = 1'b0;
                end else begin
                    id_valid_s = id_valid_r;
                end
            end
            DROP: begin
                // IF/ID already holds a bubble; a fresh branch simply retargets the refetch.
                id_inst_s  = NOP_INST;
                id_valid_s = 1'b0;
                if (br) begin
                    pc_s = word_align(br_addr);
                end else begin
                    pc_s = pc_r;
                end
                if (ack_s) begin
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            FULL: begin
                if (stall) begin
                    state_s = FULL;
                end else if (br) begin
                    pc_s        = word_align(br_addr);
                    id_inst_s   = NOP_INST;
                    id_valid_s  = 1'b0;
                    buf_valid_s = 1'b0;
                    state_s     = FETCH;
                end else begin
                    id_pc_s     = buf_pc_r;
                    id_inst_s   = buf_inst_r;
                    id_valid_s  = 1'b1;
                    buf_valid_s = 1'b0;
                    state_s     = FETCH;
                end
            end
            default: begin
                state_s     = FETCH;
                buf_valid_s = 1'b0;
                id_inst_s   = NOP_INST;
                id_valid_s  = 1'b0;
            end
        endcase
    end

    // Registered bus request: DROP keeps the stale address until its response retires.
    always_comb begin
        req_s  = (state_s != FULL);
        addr_s = (state_s == DROP) ? addr_r : word_align(pc_s);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= FETCH;
            pc_r        <= RESET_PC;
            buf_valid_r <= 1'b0;
            buf_pc_r    <= 32'h0000_0000;
            buf_inst_r  <= NOP_INST;
            req_r       <= 1'b0;
            addr_r      <= word_align(RESET_PC);
            id_pc_r     <= 32'h0000_0000;
            id_inst_r   <= NOP_INST;
            id_valid_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            buf_valid_r <= buf_valid_s;
            buf_pc_r    <= buf_pc_s;
            buf_inst_r  <= buf_inst_s;
            req_r       <= req_s;
            addr_r      <= addr_s;
            id_pc_r     <= id_pc_s;
            id_inst_r   <= id_inst_s;
            id_valid_r  <= id_valid_s;
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = addr_r;
    assign id_pc          = id_pc_r;
    assign id_inst        = id_inst_r;
    assign id_valid       = id_valid_r;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed scenarios then random stall/branch/wait-state traffic,
// every cycle compared against a queue-based model of the fetch stage.
module tb_stage_if;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] br_addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    stage_if_if bus ();

    stage_if #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br(br), .br_addr(br_addr),
        .imem(bus), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // model: PC to fetch, pending wrong-path response, words caught during a stall, ID register
    logic [31:0] m_pc, m_addr, m_id_pc, m_id_inst;
    logic        m_req, m_discard, m_id_valid;
    ent_t        held[$];

    // memory environment
    int mem_wait  = 0;
    int wcnt      = 0;
    bit rand_wait = 1'b0;
    bit force_ack = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_id_valid = 1'b0;
        m_id_inst  = NOP;
    endtask

    task automatic model_step(input logic r, input logic s, input logic b,
                              input logic [31:0] ba, input logic a);
        logic got;
        ent_t e;
        got = a & m_req;
        if (!r) begin
            m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_discard = 1'b0;
            held.delete();
            m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 1'b0;
        end else begin
            if (m_discard) begin
                if (b) m_pc = ba;
                bubble();
                if (got) m_discard = 1'b0;
            end else if (held.size() != 0) begin
                if (!s) begin
                    if (b) begin
                        m_pc = ba;
                        held.delete();
                        bubble();
                    end else begin
                        e = held.pop_front();
                        m_id_pc = e.pc; m_id_inst = e.inst; m_id_valid = 1'b1;
                    end
                end
            end else if (b && !s) begin
                m_pc = ba;
                bubble();
                if (!got) m_discard = 1'b1;
            end else if (got) begin
                e.pc = m_pc;
                e.inst = mem_word(m_pc);
                m_pc = m_pc + 32'd4;
                if (s) held.push_back(e);
                else begin
                    m_id_pc = e.pc; m_id_inst = e.inst; m_id_valid = 1'b1;
                end
            end else if (!s) begin
                bubble();
            end
            m_req = (held.size() == 0);
            if (!m_discard) m_addr = m_pc;
        end
    endtask

    task automatic check_outputs();
        chk("req", {31'h0, bus.imem_req}, {31'h0, m_req});
        if (m_req) chk("addr", bus.imem_addr, m_addr);
        chk("valid", {31'h0, id_valid}, {31'h0, m_id_valid});
        chk("inst", id_inst, m_id_inst);
        if (m_id_valid) chk("pc", id_pc, m_id_pc);
    endtask

    task automatic tick(input logic s, input logic b, input logic [31:0] ba);
        logic a, rq, r;
        stall = s; br = b; br_addr = ba;
        rq = bus.imem_req;
        r  = rst;
        a  = force_ack | (rq & (wcnt >= mem_wait));
        bus.imem_ack   = a;
        bus.imem_rdata = mem_word(bus.imem_addr);
        @(posedge clk);
        model_step(r, s, b, ba, a);
        if (!r) wcnt = 0;
        else if (rq && a) begin
            wcnt = 0;
            if (rand_wait) mem_wait = $urandom_range(0, 2);
        end else if (rq) wcnt++;
        #1;
        check_outputs();
    endtask

    initial begin
        bit          found;
        logic        s, b;
        logic [31:0] ba;
        rst = 1'b0; stall = 1'b0; br = 1'b0; br_addr = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        #2;

        // 1: reset then zero-wait streaming
        tick(1'b0, 1'b0, 32'h0);
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_inst", id_inst, NOP);
        chk("rst_pc", id_pc, 32'h0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 32'h0);
        chk("t1_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t1_addr", bus.imem_addr, 32'h0);
        chk("t1_valid0", {31'h0, id_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            chk("t1_valid", {31'h0, id_valid}, 32'h1);
            chk("t1_pc", id_pc, 32'(4 * i));
            chk("t1_inst", id_inst, mem_word(32'(4 * i)));
        end

        // 2: three-cycle stall while a response lands
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            chk("t2_hold_pc", id_pc, 32'h0000_000C);
            chk("t2_req_off", {31'h0, bus.imem_req}, 32'h0);
        end
        tick(1'b0, 1'b0, 32'h0);
        chk("t2_buf_pc", id_pc, 32'h0000_0010);
        chk("t2_buf_inst", id_inst, mem_word(32'h0000_0010));
        tick(1'b0, 1'b0, 32'h0);
        chk("t2_next_pc", id_pc, 32'h0000_0014);

        // 3: taken branch with same-cycle ack
        tick(1'b0, 1'b1, 32'h0000_0100);
        chk("t3_bubble", {31'h0, id_valid}, 32'h0);
        chk("t3_nop", id_inst, NOP);
        tick(1'b0, 1'b0, 32'h0);
        chk("t3_target_pc", id_pc, 32'h0000_0100);
        chk("t3_target_valid", {31'h0, id_valid}, 32'h1);

        // 4: two wait states, branch with request outstanding
        mem_wait = 2;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_0100);
        chk("t4_stale_addr", bus.imem_addr, 32'h0000_0104);
        chk("t4_stale_req", {31'h0, bus.imem_req}, 32'h1);
        tick(1'b0, 1'b0, 32'h0);
        chk("t4_new_addr", bus.imem_addr, 32'h0000_0100);
        chk("t4_dropped", {31'h0, id_valid}, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (id_valid) found = 1'b1;
        end
        chk("t4_arrive", {31'h0, found}, 32'h1);
        chk("t4_pc", id_pc, 32'h0000_0100);

        // 5: branch ignored under stall, honoured after
        mem_wait = 0;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h0000_0300);
        chk("t5_hold_pc", id_pc, 32'h0000_0104);
        tick(1'b1, 1'b1, 32'h0000_0300);
        chk("t5_hold_pc2", id_pc, 32'h0000_0104);
        tick(1'b0, 1'b1, 32'h0000_0300);
        chk("t5_redir_addr", bus.imem_addr, 32'h0000_0300);
        chk("t5_bubble", {31'h0, id_valid}, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk("t5_target_pc", id_pc, 32'h0000_0300);

        // PC wrap at the top of the address space
        tick(1'b0, 1'b1, 32'hFFFF_FFF8);
        tick(1'b0, 1'b0, 32'h0);
        chk("wrap_pc0", id_pc, 32'hFFFF_FFF8);
        tick(1'b0, 1'b0, 32'h0);
        chk("wrap_pc1", id_pc, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        chk("wrap_pc2", id_pc, 32'h0000_0000);

        // 6: reset mid-request, late ack afterwards
        mem_wait = 3;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        rst = 1'b0; force_ack = 1'b1;
        tick(1'b0, 1'b0, 32'h0);
        chk("t6_req", {31'h0, bus.imem_req}, 32'h0);
        chk("t6_valid", {31'h0, id_valid}, 32'h0);
        chk("t6_inst", id_inst, NOP);
        rst = 1'b1;
        tick(1'b0, 1'b0, 32'h0);
        chk("t6_restart_addr", bus.imem_addr, 32'h0);
        chk("t6_late_ignored", {31'h0, id_valid}, 32'h0);
        force_ack = 1'b0; mem_wait = 0;
        tick(1'b0, 1'b0, 32'h0);
        chk("t6_first_pc", id_pc, 32'h0);
        chk("t6_first_inst", id_inst, mem_word(32'h0));

        // random traffic
        rand_wait = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            force_ack = !rst && ($urandom_range(0, 1) == 1);
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'h0000_000C))
                                            : ($urandom() & 32'hFFFF_FFFC);
            tick(s, b, ba);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
